// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port.
// slave  = the arbiter side, master = pipeline + memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_data, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_data, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between instruction fetch
// and the load/store path. Data wins unless fetch has been passed over STARVE_LIMIT times.
// Optional feature macro: ARB_PERF_EN adds stall-cycle and forced-fetch counters.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [15:0]       perf_starve_forces
`endif
);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [STV_W-1:0] starve_reg, starve_next;
  logic             mem_en_reg, mem_en_next;
  logic             mem_we_reg, mem_we_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic [31:0]      mem_wdata_reg, mem_wdata_next;
  logic             if_ready_reg, if_ready_next;
  logic             d_ready_reg, d_ready_next;
  logic [31:0]      if_data_reg, if_data_next;
  logic [31:0]      d_rdata_reg, d_rdata_next;
  logic             force_grant;
  logic             if_elig, d_elig, stall_w;

  // A request whose ready pulse is showing this cycle has just been served.
  assign if_elig = bus.if_req & ~if_ready_reg;
  assign d_elig  = bus.d_req & ~d_ready_reg;
  assign stall_w = (bus.if_req & ~if_ready_reg) | (bus.d_req & ~d_ready_reg);

  assign bus.stall     = stall_w;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.d_ready   = d_ready_reg;
  assign bus.if_data   = if_data_reg;
  assign bus.d_rdata   = d_rdata_reg;

  // State and registered outputs; reset discards any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      starve_reg    <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ready_reg  <= 1'b0;
      d_ready_reg   <= 1'b0;
      if_data_reg   <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      starve_reg    <= starve_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_ready_reg  <= if_ready_next;
      d_ready_reg   <= d_ready_next;
      if_data_reg   <= if_data_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  // Grant decision in IDLE, latency countdown and read-data capture in BUSY.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    starve_next    = starve_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_ready_next  = 1'b0;
    d_ready_next   = 1'b0;
    if_data_next   = if_data_reg;
    d_rdata_next   = d_rdata_reg;
    force_grant    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_elig && !((starve_reg == STV_MAX) && if_elig)) begin
          state_next     = BUSY_D;
          cnt_next       = CNT_LOAD;
          mem_en_next    = 1'b1;
          mem_we_next    = bus.d_we;
          mem_addr_next  = bus.d_addr;
          mem_wdata_next = bus.d_wdata;
          if (if_elig) begin
            starve_next = (starve_reg == STV_MAX) ? starve_reg : starve_reg + STV_ONE;
          end else begin
            starve_next = '0;
          end
        end else if (if_elig) begin
          state_next    = BUSY_I;
          cnt_next      = CNT_LOAD;
          mem_en_next   = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = bus.if_addr;
          starve_next   = '0;
          force_grant   = d_elig;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_reg == CNT_ONE) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (state_reg == BUSY_I) begin
            if_ready_next = 1'b1;
            if_data_next  = bus.mem_rdata;
          end else begin
            d_ready_next = 1'b1;
            if (!mem_we_reg) begin
              d_rdata_next = bus.mem_rdata;
            end
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef ARB_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [15:0] force_cnt_reg;

  // Saturating counters of stalled cycles and of fetches forced past waiting data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      force_cnt_reg <= '0;
    end else begin
      if (stall_w && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (force_grant && (force_cnt_reg != 16'hFFFF)) begin
        force_cnt_reg <= force_cnt_reg + 16'd1;
      end
    end
  end

  assign perf_stall_cycles  = stall_cnt_reg;
  assign perf_starve_forces = force_cnt_reg;
`endif
endmodule
